// File: rtl/ucdp_sync_filt.sv
// Multi-channel level synchronizer with optional deglitch filter and edge pulses.
// Macro UCDP_SYNC_JITTER_EN (with SIM) emulates metastability by randomly delaying edges one cycle.
module ucdp_sync_filt #(
    parameter int               WIDTH    = 1,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '1,
    parameter int               FILT_LEN = 0
) (
    input  logic             main_clk_i,
    input  logic             main_rst_an_i,
    input  logic             scan_shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int unsigned CNT_W = (FILT_LEN > 0) ? $clog2(FILT_LEN + 1) : 1;

    if (STAGES < 2) begin : g_err_stages
        $error("ucdp_sync_filt: STAGES must be >= 2");
    end
    if (WIDTH < 1) begin : g_err_width
        $error("ucdp_sync_filt: WIDTH must be >= 1");
    end
    if (FILT_LEN < 0) begin : g_err_filt
        $error("ucdp_sync_filt: FILT_LEN must be >= 0");
    end

    logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0]             d_sel;
    logic [WIDTH-1:0]             s;
    logic [WIDTH-1:0]             prev_q, prev_d;

    assign s = stage_q[STAGES-1];

`ifdef UCDP_SYNC_JITTER_EN
`ifdef SIM
    // Edge lands 0 or +1 cycle late; select only changes while d_i is stable.
    logic [WIDTH-1:0] jd_q, jd_d;
    logic [WIDTH-1:0] sel_q;
    logic [WIDTH-1:0] redraw;

    always_comb begin
        jd_d   = d_i;
        redraw = (~(jd_q ^ d_i)) & (stage_q[0] ^ stage_q[1]);
        d_sel  = (sel_q & jd_q) | (~sel_q & d_i);
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            jd_q  <= RST_VAL;
            sel_q <= '0;
        end else begin
            jd_q <= jd_d;
            for (int i = 0; i < WIDTH; i++) begin
                if (redraw[i]) sel_q[i] <= 1'($random);
            end
        end
    end
`else
    assign d_sel = d_i;
`endif
`else
    assign d_sel = d_i;
`endif

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d_sel};
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            stage_q <= {STAGES{RST_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    if (FILT_LEN == 0) begin : g_nofilt
        logic unused_scan;
        assign unused_scan = scan_shift_i;
        assign q_o         = s;
    end else begin : g_filt
        localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

        logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0]            filt_q, filt_d;

        // Per channel: accept a new level only after FILT_LEN consecutive mismatching cycles.
        always_comb begin
            filt_d = filt_q;
            cnt_d  = cnt_q;
            for (int i = 0; i < WIDTH; i++) begin
                if (scan_shift_i) begin
                    filt_d[i] = s[i];
                    cnt_d[i]  = '0;
                end else if (s[i] == filt_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    filt_d[i] = s[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
            if (!main_rst_an_i) begin
                filt_q <= RST_VAL;
                cnt_q  <= '0;
            end else begin
                filt_q <= filt_d;
                cnt_q  <= cnt_d;
            end
        end

        assign q_o = filt_q;
    end

    always_comb begin
        prev_d = q_o;
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: tb/tb_ucdp_sync_filt.sv
// Directed bench for ucdp_sync_filt: filtered instance (FILT_LEN=3) and bypass instance (FILT_LEN=0).
module tb_ucdp_sync_filt;

    localparam int W = 4;
    localparam logic [W-1:0] RV = 4'b1010;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         scan;
    logic [W-1:0] d;
    logic [W-1:0] q, rise, fall;
    logic [W-1:0] q0, rise0, fall0;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ucdp_sync_filt #(.WIDTH(W), .STAGES(2), .RST_VAL(RV), .FILT_LEN(3)) dut (
        .main_clk_i   (clk),
        .main_rst_an_i(rst_n),
        .scan_shift_i (scan),
        .d_i          (d),
        .q_o          (q),
        .rise_o       (rise),
        .fall_o       (fall)
    );

    ucdp_sync_filt #(.WIDTH(W), .STAGES(2), .RST_VAL(RV), .FILT_LEN(0)) dut0 (
        .main_clk_i   (clk),
        .main_rst_an_i(rst_n),
        .scan_shift_i (scan),
        .d_i          (d),
        .q_o          (q0),
        .rise_o       (rise0),
        .fall_o       (fall0)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [W-1:0] dd, input logic [W-1:0] qq,
                       input logic [W-1:0] rr, input logic [W-1:0] ff, input int n);
        vec_t v;
        v.d = dd; v.q = qq; v.rise = rr; v.fall = ff;
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and quiet period
        rst_n = 1'b0;
        scan  = 1'b0;
        d     = RV;
        #12;
        check("reset_q", q, RV);
        check("reset_rise", rise, 4'b0000);
        check("reset_fall", fall, 4'b0000);
        check("reset_q0", q0, RV);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_q", q, RV);
            check("idle_pulse", rise | fall, 4'b0000);
        end

        // Per-cycle vectors: d applied, then one edge, then q/rise/fall compared
        add(4'b1011, 4'b1010, 4'b0000, 4'b0000, 4);   // bit0 rises: 5 edges
        add(4'b1011, 4'b1011, 4'b0001, 4'b0000, 1);
        add(4'b1011, 4'b1011, 4'b0000, 4'b0000, 1);
        add(4'b1111, 4'b1011, 4'b0000, 4'b0000, 4);   // bit2 rises cleanly
        add(4'b1111, 4'b1111, 4'b0100, 4'b0000, 1);
        add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1);
        add(4'b1011, 4'b1111, 4'b0000, 4'b0000, 2);   // bit2 low for 2 cycles: rejected
        add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 5);
        add(4'b1011, 4'b1111, 4'b0000, 4'b0000, 4);   // bit2 low held: falls after 5 edges
        add(4'b1011, 4'b1011, 4'b0000, 4'b0100, 1);
        add(4'b1011, 4'b1011, 4'b0000, 4'b0000, 1);
        add(4'b0011, 4'b1011, 4'b0000, 4'b0000, 2);   // bit3 bounce restarts count
        add(4'b1011, 4'b1011, 4'b0000, 4'b0000, 1);
        add(4'b0011, 4'b1011, 4'b0000, 4'b0000, 4);
        add(4'b0011, 4'b0011, 4'b0000, 4'b1000, 1);
        add(4'b0011, 4'b0011, 4'b0000, 4'b0000, 1);
        foreach (vecs[i]) begin
            d = vecs[i].d;
            tick();
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_rise", i), rise, vecs[i].rise);
            check($sformatf("vec%0d_fall", i), fall, vecs[i].fall);
        end

        // Reset while bit0 counter is at 2
        d = 4'b0010;
        repeat (4) tick();
        check("midcnt_q", q, 4'b0011);
        #2;
        rst_n = 1'b0;
        d     = RV;
        #1;
        check("async_rst_q", q, RV);
        check("async_rst_pulse", rise | fall, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rel_q", q, RV);
            check("rel_pulse", rise | fall, 4'b0000);
        end
        d = 4'b1011;
        repeat (4) tick();
        check("restart_q4", q, RV);
        tick();
        check("restart_q5", q, 4'b1011);
        check("restart_rise", rise, 4'b0001);

        // Scan shift bypasses the filter
        scan = 1'b1;
        d    = 4'b0101;
        tick();
        check("scan_q_e1", q, 4'b1011);
        check("scan_q0_e1", q0, 4'b1011);
        tick();
        check("scan_q_e2", q, 4'b1011);
        check("scan_q0_e2", q0, 4'b0101);
        check("scan_rise0", rise0, 4'b0100);
        check("scan_fall0", fall0, 4'b1010);
        tick();
        check("scan_q_e3", q, 4'b0101);
        check("scan_rise", rise, 4'b0100);
        check("scan_fall", fall, 4'b1010);
        scan = 1'b0;
        repeat (2) tick();

`ifdef UCDP_SYNC_JITTER_EN
        begin
            int pulses;
            int changes;
            bit seen5;
            bit seen6;
            pulses  = 0;
            changes = 0;
            seen5   = 1'b0;
            seen6   = 1'b0;
            for (int n = 0; n < 200; n++) begin
                int           c;
                int           lat;
                logic [W-1:0] qold;
                c    = int'($urandom_range(0, W - 1));
                qold = q;
                d[c] = ~d[c];
                lat  = 0;
                for (int e = 1; e <= 10; e++) begin
                    tick();
                    pulses += $countones(rise | fall);
                    if (q[c] !== qold[c]) begin
                        lat = e;
                        break;
                    end
                end
                changes++;
                checks++;
                if (lat != 5 && lat != 6) begin
                    errors++;
                    $display("FAIL jitter_latency: got %0d expected 5 or 6", lat);
                end
                if (lat == 5) seen5 = 1'b1;
                if (lat == 6) seen6 = 1'b1;
            end
            repeat (8) begin
                tick();
                pulses += $countones(rise | fall);
            end
            checks++;
            if (pulses != changes) begin
                errors++;
                $display("FAIL jitter_pulses: got %0d expected %0d", pulses, changes);
            end
            checks++;
            if (!(seen5 && seen6)) begin
                errors++;
                $display("FAIL jitter_both_latencies: got seen5=%0d seen6=%0d expected 1 1", seen5, seen6);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
